// File: rtl/ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: opcode numbers, FSM states
// and the positions of the register fields inside the instruction word.
package ctrl_pkg;

    localparam int unsigned OP_ADD  = 3;
    localparam int unsigned OP_SUB  = 4;
    localparam int unsigned OP_AND  = 5;
    localparam int unsigned OP_OR   = 6;
    localparam int unsigned OP_SHR  = 7;
    localparam int unsigned OP_SHRA = 8;
    localparam int unsigned OP_SHL  = 9;
    localparam int unsigned OP_ROR  = 10;
    localparam int unsigned OP_ROL  = 11;
    localparam int unsigned OP_MUL  = 15;
    localparam int unsigned OP_DIV  = 16;
    localparam int unsigned OP_NEG  = 17;
    localparam int unsigned OP_NOT  = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6
    } state_t;

    // Register fields are packed Ra, Rb, Rc directly below the opcode.
    localparam int REG_FIELD_RA = 0;
    localparam int REG_FIELD_RB = 1;
    localparam int REG_FIELD_RC = 2;

    function automatic int reg_field_lsb(input int data_width, input int opcode_width,
                                         input int reg_addr_width, input int field);
        return data_width - opcode_width - (field + 1) * reg_addr_width;
    endfunction

endpackage

// File: rtl/op_class_decode.sv
// Combinational classification of an opcode into the instruction class that
// selects the execute sequence.
module op_class_decode
    import ctrl_pkg::*;
#(
    parameter int OPCODE_WIDTH = 5
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    arith3,
    output logic                    unary,
    output logic                    muldiv,
    output logic                    illegal
);

    logic [31:0] opc;

    assign opc     = 32'(opcode);
    assign arith3  = (opc >= OP_ADD) && (opc <= OP_ROL);
    assign unary   = (opc == OP_NEG) || (opc == OP_NOT);
    assign muldiv  = (opc == OP_MUL) || (opc == OP_DIV);
    assign illegal = !(arith3 || unary || muldiv);

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Moore control sequencer for register ALU instructions: fetch (T0-T2) then a
// class-dependent execute sequence (T3-T6), one control word per clock.
module alu_ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_WIDTH   = 5,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int MEM_WAIT       = 0,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      run,
    input  logic [DATA_WIDTH-1:0]     IR_Data,
    output logic                      PC_out,
    output logic                      MAR_in,
    output logic                      IncPC,
    output logic                      Z_in,
    output logic                      Zlow_out,
    output logic                      Zhigh_out,
    output logic                      PC_in,
    output logic                      Read,
    output logic                      MDR_in,
    output logic                      MDR_out,
    output logic                      IR_in,
    output logic                      Y_in,
    output logic                      R_in,
    output logic                      R_out,
    output logic                      HI_in,
    output logic                      LO_in,
    output logic [REG_ADDR_WIDTH-1:0] reg_sel,
    output logic [OPCODE_WIDTH-1:0]   alu_instruction,
    output logic                      busy,
    output logic                      done,
    output logic                      illegal,
    output logic [COUNT_WIDTH-1:0]    instr_count
);

    localparam int OPC_LSB = DATA_WIDTH - OPCODE_WIDTH;
    localparam int RA_LSB  = reg_field_lsb(DATA_WIDTH, OPCODE_WIDTH, REG_ADDR_WIDTH, REG_FIELD_RA);
    localparam int RB_LSB  = reg_field_lsb(DATA_WIDTH, OPCODE_WIDTH, REG_ADDR_WIDTH, REG_FIELD_RB);
    localparam int RC_LSB  = reg_field_lsb(DATA_WIDTH, OPCODE_WIDTH, REG_ADDR_WIDTH, REG_FIELD_RC);
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t                    state;
    logic [3:0]                wait_cnt;
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [REG_ADDR_WIDTH-1:0] ra, rb, rc;
    logic                      cls_arith3, cls_unary, cls_muldiv, cls_illegal;

    assign opcode = IR_Data[OPC_LSB +: OPCODE_WIDTH];
    assign ra     = IR_Data[RA_LSB +: REG_ADDR_WIDTH];
    assign rb     = IR_Data[RB_LSB +: REG_ADDR_WIDTH];
    assign rc     = IR_Data[RC_LSB +: REG_ADDR_WIDTH];

    // Immediate/low bits of the instruction word are not used by these instructions.
    if (RC_LSB > 0) begin : g_ir_low
        logic unused_ir_low;
        assign unused_ir_low = ^IR_Data[RC_LSB-1:0];
    end

    op_class_decode #(
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_op_class_decode (
        .opcode (opcode),
        .arith3 (cls_arith3),
        .unary  (cls_unary),
        .muldiv (cls_muldiv),
        .illegal(cls_illegal)
    );

    assign busy = (state != ST_IDLE);
    assign done = ((state == ST_T5) && !cls_muldiv) || (state == ST_T6);

    // The end of an instruction is the cycle done is high; run is only looked at there and in IDLE.
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else if (done) begin
            state       <= run ? ST_T0 : ST_IDLE;
            instr_count <= instr_count + 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (run) state <= ST_T0;
                ST_T0: begin
                    state    <= ST_T1;
                    wait_cnt <= '0;
                end
                ST_T1: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state    <= ST_T2;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_T2: state <= ST_T3;
                ST_T3: begin
                    if (cls_unary)        state <= ST_T5;
                    else if (cls_illegal) state <= ST_IDLE;
                    else                  state <= ST_T4;
                end
                ST_T4:   state <= ST_T5;
                ST_T5:   state <= ST_T6;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        PC_out          = 1'b0;
        MAR_in          = 1'b0;
        IncPC           = 1'b0;
        Z_in            = 1'b0;
        Zlow_out        = 1'b0;
        Zhigh_out       = 1'b0;
        PC_in           = 1'b0;
        Read            = 1'b0;
        MDR_in          = 1'b0;
        MDR_out         = 1'b0;
        IR_in           = 1'b0;
        Y_in            = 1'b0;
        R_in            = 1'b0;
        R_out           = 1'b0;
        HI_in           = 1'b0;
        LO_in           = 1'b0;
        reg_sel         = '0;
        alu_instruction = '0;
        illegal         = 1'b0;
        case (state)
            ST_T0: begin
                PC_out = 1'b1;
                MAR_in = 1'b1;
                IncPC  = 1'b1;
                Z_in   = 1'b1;
            end
            ST_T1: begin
                Read   = 1'b1;
                MDR_in = 1'b1;
                // PC write-back happens only once, on the first cycle of the memory read.
                if (wait_cnt == '0) begin
                    Zlow_out = 1'b1;
                    PC_in    = 1'b1;
                end
            end
            ST_T2: begin
                MDR_out = 1'b1;
                IR_in   = 1'b1;
            end
            ST_T3: begin
                if (cls_unary) begin
                    R_out           = 1'b1;
                    reg_sel         = rb;
                    alu_instruction = opcode;
                    Z_in            = 1'b1;
                end else if (cls_muldiv) begin
                    R_out   = 1'b1;
                    reg_sel = ra;
                    Y_in    = 1'b1;
                end else if (cls_arith3) begin
                    R_out   = 1'b1;
                    reg_sel = rb;
                    Y_in    = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            ST_T4: begin
                R_out           = 1'b1;
                reg_sel         = cls_muldiv ? rb : rc;
                alu_instruction = opcode;
                Z_in            = 1'b1;
            end
            ST_T5: begin
                Zlow_out = 1'b1;
                if (cls_muldiv) begin
                    LO_in = 1'b1;
                end else begin
                    R_in    = 1'b1;
                    reg_sel = ra;
                end
            end
            ST_T6: begin
                Zhigh_out = 1'b1;
                HI_in     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Bench for alu_ctrl_sequencer: two instances (MEM_WAIT=0 and MEM_WAIT=2 with a
// 2-bit counter) checked every cycle against an instruction-level sequence model.
module tb_alu_ctrl_sequencer;

    // control word bit masks, bit 0 = PC_out ... bit 15 = LO_in
    localparam logic [15:0] M_PC_OUT    = 16'h0001;
    localparam logic [15:0] M_MAR_IN    = 16'h0002;
    localparam logic [15:0] M_INC_PC    = 16'h0004;
    localparam logic [15:0] M_Z_IN      = 16'h0008;
    localparam logic [15:0] M_ZLOW_OUT  = 16'h0010;
    localparam logic [15:0] M_ZHIGH_OUT = 16'h0020;
    localparam logic [15:0] M_PC_IN     = 16'h0040;
    localparam logic [15:0] M_READ      = 16'h0080;
    localparam logic [15:0] M_MDR_IN    = 16'h0100;
    localparam logic [15:0] M_MDR_OUT   = 16'h0200;
    localparam logic [15:0] M_IR_IN     = 16'h0400;
    localparam logic [15:0] M_Y_IN      = 16'h0800;
    localparam logic [15:0] M_R_IN      = 16'h1000;
    localparam logic [15:0] M_R_OUT     = 16'h2000;
    localparam logic [15:0] M_HI_IN     = 16'h4000;
    localparam logic [15:0] M_LO_IN     = 16'h8000;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr0 = 1'b1, run0 = 1'b0, clr2 = 1'b1, run2 = 1'b0;
    logic [31:0] ir0 = '0, ir2 = '0;
    logic [15:0] c0, c2;
    logic [3:0]  rs0, rs2;
    logic [4:0]  alu0, alu2;
    logic        busy0, done0, ill0, busy2, done2, ill2;
    logic [15:0] cnt_act0;
    logic [1:0]  cnt_act2;
    logic [27:0] act0, act2;

    assign act0 = {ill0, done0, busy0, alu0, rs0, c0};
    assign act2 = {ill2, done2, busy2, alu2, rs2, c2};

    alu_ctrl_sequencer #(.MEM_WAIT(0)) dut0 (
        .clk(clk), .clr(clr0), .run(run0), .IR_Data(ir0),
        .PC_out(c0[0]), .MAR_in(c0[1]), .IncPC(c0[2]), .Z_in(c0[3]),
        .Zlow_out(c0[4]), .Zhigh_out(c0[5]), .PC_in(c0[6]), .Read(c0[7]),
        .MDR_in(c0[8]), .MDR_out(c0[9]), .IR_in(c0[10]), .Y_in(c0[11]),
        .R_in(c0[12]), .R_out(c0[13]), .HI_in(c0[14]), .LO_in(c0[15]),
        .reg_sel(rs0), .alu_instruction(alu0), .busy(busy0), .done(done0),
        .illegal(ill0), .instr_count(cnt_act0)
    );

    alu_ctrl_sequencer #(.MEM_WAIT(2), .COUNT_WIDTH(2)) dut2 (
        .clk(clk), .clr(clr2), .run(run2), .IR_Data(ir2),
        .PC_out(c2[0]), .MAR_in(c2[1]), .IncPC(c2[2]), .Z_in(c2[3]),
        .Zlow_out(c2[4]), .Zhigh_out(c2[5]), .PC_in(c2[6]), .Read(c2[7]),
        .MDR_in(c2[8]), .MDR_out(c2[9]), .IR_in(c2[10]), .Y_in(c2[11]),
        .R_in(c2[12]), .R_out(c2[13]), .HI_in(c2[14]), .LO_in(c2[15]),
        .reg_sel(rs2), .alu_instruction(alu2), .busy(busy2), .done(done2),
        .illegal(ill2), .instr_count(cnt_act2)
    );

    // scoreboard: one expected output word per upcoming cycle; empty queue means IDLE
    logic [27:0] exp_q0[$];
    logic [27:0] exp_q2[$];
    logic [15:0] cnt0 = '0;
    logic [1:0]  cnt2 = '0;
    int          checks = 0;
    int          errors = 0;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [27:0] w(input logic [15:0] c, input logic [3:0] rs,
                                      input logic [4:0] alu, input logic dn, input logic il);
        return {il, dn, 1'b1, alu, rs, c};
    endfunction

    task automatic push_word(input int d, input logic [27:0] x);
        if (d == 0) exp_q0.push_back(x);
        else        exp_q2.push_back(x);
    endtask

    // Expected per-cycle control words of one instruction, straight from the instruction rules.
    task automatic build_seq(input int d, input logic [31:0] ir);
        int         op, mw;
        logic [3:0] ra, rb, rc;
        logic [4:0] opc;
        mw  = (d == 0) ? 0 : 2;
        opc = ir[31:27];
        op  = int'(opc);
        ra  = ir[26:23];
        rb  = ir[22:19];
        rc  = ir[18:15];
        push_word(d, w(M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN, 4'd0, 5'd0, 1'b0, 1'b0));
        push_word(d, w(M_ZLOW_OUT | M_PC_IN | M_READ | M_MDR_IN, 4'd0, 5'd0, 1'b0, 1'b0));
        for (int i = 0; i < mw; i++) push_word(d, w(M_READ | M_MDR_IN, 4'd0, 5'd0, 1'b0, 1'b0));
        push_word(d, w(M_MDR_OUT | M_IR_IN, 4'd0, 5'd0, 1'b0, 1'b0));
        if (op >= 3 && op <= 11) begin
            push_word(d, w(M_R_OUT | M_Y_IN, rb, 5'd0, 1'b0, 1'b0));
            push_word(d, w(M_R_OUT | M_Z_IN, rc, opc, 1'b0, 1'b0));
            push_word(d, w(M_ZLOW_OUT | M_R_IN, ra, 5'd0, 1'b1, 1'b0));
        end else if (op == 17 || op == 18) begin
            push_word(d, w(M_R_OUT | M_Z_IN, rb, opc, 1'b0, 1'b0));
            push_word(d, w(M_ZLOW_OUT | M_R_IN, ra, 5'd0, 1'b1, 1'b0));
        end else if (op == 15 || op == 16) begin
            push_word(d, w(M_R_OUT | M_Y_IN, ra, 5'd0, 1'b0, 1'b0));
            push_word(d, w(M_R_OUT | M_Z_IN, rb, opc, 1'b0, 1'b0));
            push_word(d, w(M_ZLOW_OUT | M_LO_IN, 4'd0, 5'd0, 1'b0, 1'b0));
            push_word(d, w(M_ZHIGH_OUT | M_HI_IN, 4'd0, 5'd0, 1'b1, 1'b0));
        end else begin
            push_word(d, w(16'h0000, 4'd0, 5'd0, 1'b0, 1'b1));
        end
    endtask

    // compare process: every cycle, 3 time units after the rising edge
    initial begin
        logic [27:0] e;
        forever begin
            @(posedge clk);
            #3;
            if (chk_en) begin
                e = '0;
                if (exp_q0.size() > 0) e = exp_q0.pop_front();
                check("dut0 outputs", 32'(act0), 32'(e));
                check("dut0 instr_count", 32'(cnt_act0), 32'(cnt0));
                if (e[26]) cnt0 = cnt0 + 16'd1;
                e = '0;
                if (exp_q2.size() > 0) e = exp_q2.pop_front();
                check("dut2 outputs", 32'(act2), 32'(e));
                check("dut2 instr_count", 32'(cnt_act2), 32'(cnt2));
                if (e[26]) cnt2 = cnt2 + 2'd1;
            end
        end
    end

    // directed stimulus, driven on falling edges
    initial begin
        logic [31:0] prog [5];
        int          lens [5];
        prog[0] = 32'h191A0000; lens[0] = 8;   // add R2,R3,R4
        prog[1] = 32'h79A00000; lens[1] = 9;   // mul R3,R4
        prog[2] = 32'h92B00000; lens[2] = 7;   // not R5,R6
        prog[3] = 32'h83C00000; lens[3] = 9;   // div R7,R8
        prog[4] = 32'h58918000; lens[4] = 8;   // rol R1,R2,R3

        repeat (3) @(negedge clk);
        clr0 = 1'b0;
        clr2 = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy0), 32'd0);

        // neg R0,R1 with a one-cycle run pulse
        @(negedge clk);
        ir0 = 32'h88080000; run0 = 1'b1; build_seq(0, ir0);
        check("neg model length", 32'(exp_q0.size()), 32'd5);
        @(negedge clk); run0 = 1'b0;
        repeat (3) @(negedge clk);
        check("neg T3 controls", 32'(c0), 32'(M_R_OUT | M_Z_IN));
        check("neg T3 reg_sel", 32'(rs0), 32'd1);
        check("neg T3 alu", 32'(alu0), 32'd17);
        @(negedge clk);
        check("neg T5 done", 32'(done0), 32'd1);
        check("neg T5 controls", 32'(c0), 32'(M_ZLOW_OUT | M_R_IN));
        check("neg T5 reg_sel", 32'(rs0), 32'd0);
        @(negedge clk);
        check("neg count", 32'(cnt_act0), 32'd1);
        check("neg back to idle", 32'(busy0), 32'd0);

        // add R2,R3,R4
        @(negedge clk);
        ir0 = 32'h191A0000; run0 = 1'b1; build_seq(0, ir0);
        check("add model length", 32'(exp_q0.size()), 32'd6);
        @(negedge clk); run0 = 1'b0;
        repeat (3) @(negedge clk);
        check("add T3 reg_sel", 32'(rs0), 32'd3);
        check("add T3 controls", 32'(c0), 32'(M_R_OUT | M_Y_IN));
        @(negedge clk);
        check("add T4 reg_sel", 32'(rs0), 32'd4);
        check("add T4 alu", 32'(alu0), 32'd3);
        @(negedge clk);
        check("add T5 reg_sel", 32'(rs0), 32'd2);
        check("add T5 done", 32'(done0), 32'd1);
        @(negedge clk);
        check("add count", 32'(cnt_act0), 32'd2);

        // mul R3,R4
        @(negedge clk);
        ir0 = 32'h79A00000; run0 = 1'b1; build_seq(0, ir0);
        check("mul model length", 32'(exp_q0.size()), 32'd7);
        @(negedge clk); run0 = 1'b0;
        repeat (5) @(negedge clk);
        check("mul T5 controls", 32'(c0), 32'(M_ZLOW_OUT | M_LO_IN));
        check("mul T5 done", 32'(done0), 32'd0);
        @(negedge clk);
        check("mul T6 controls", 32'(c0), 32'(M_ZHIGH_OUT | M_HI_IN));
        check("mul T6 done", 32'(done0), 32'd1);
        @(negedge clk);
        check("mul count", 32'(cnt_act0), 32'd3);

        // illegal opcode 31
        @(negedge clk);
        ir0 = 32'hF8000000; run0 = 1'b1; build_seq(0, ir0);
        check("illegal model length", 32'(exp_q0.size()), 32'd4);
        @(negedge clk); run0 = 1'b0;
        repeat (3) @(negedge clk);
        check("illegal pulse", 32'(ill0), 32'd1);
        check("illegal no done", 32'(done0), 32'd0);
        @(negedge clk);
        check("illegal to idle", 32'(busy0), 32'd0);
        check("illegal count held", 32'(cnt_act0), 32'd3);

        // clr during T4 of an add, run held high throughout
        @(negedge clk);
        ir0 = 32'h191A0000; run0 = 1'b1; build_seq(0, ir0);
        repeat (5) @(negedge clk);
        check("abort add in T4", 32'(alu0), 32'd3);
        clr0 = 1'b1; exp_q0.delete(); cnt0 = '0;
        @(negedge clk);
        check("clr outputs zero", 32'(act0), 32'd0);
        check("clr count zero", 32'(cnt_act0), 32'd0);
        clr0 = 1'b0; build_seq(0, ir0);
        @(negedge clk);
        check("fresh T0 after clr", 32'(c0), 32'(M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN));
        run0 = 1'b0;
        repeat (6) @(negedge clk);
        check("post-clr add count", 32'(cnt_act0), 32'd1);

        // MEM_WAIT=2, five back-to-back instructions, 2-bit counter wraps
        ir2 = prog[0]; run2 = 1'b1;
        for (int k = 0; k < 5; k++) build_seq(2, prog[k]);
        check("burst model length", 32'(exp_q2.size()), 32'd41);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            ir2 = prog[k];
            if (k == 4) begin
                @(negedge clk);
                run2 = 1'b0;
                repeat (lens[k] - 1) @(negedge clk);
            end else begin
                repeat (lens[k]) @(negedge clk);
            end
        end
        check("burst count wrapped", 32'(cnt_act2), 32'd1);
        check("burst ends idle", 32'(busy2), 32'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_sequencer.md
# alu_ctrl_sequencer

Parametrised control sequencer that drives the datapath's control inputs through the full fetch/execute sequence for register ALU instructions: three-operand, unary (neg/not) and two-step mul/div with HI/LO write-back. It replaces hand-sequenced T0–T4 control with a Moore FSM that decodes the instruction register and emits one control word per clock. It supports a variable memory wait, back-to-back instructions, illegal-opcode trapping and a retired-instruction counter.

## Interface
- DATA_WIDTH, 32: IR width; opcode field is the top OPCODE_WIDTH bits.
- OPCODE_WIDTH, 5: opcode field width.
- REG_ADDR_WIDTH, 4: width of the Ra/Rb/Rc fields. Ra sits directly below the opcode, Rb below Ra, Rc below Rb.
- MEM_WAIT, 0: extra cycles Read/MDR_in are held in T1 (0..15).
- COUNT_WIDTH, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- run  in  1  level; start/continue fetching.
- IR_Data  in  DATA_WIDTH  instruction register contents.
- PC_out, MAR_in, IncPC, Z_in, Zlow_out, Zhigh_out, PC_in, Read, MDR_in, MDR_out, IR_in, Y_in, R_in, R_out, HI_in, LO_in  out  1 each  datapath controls.
- reg_sel  out  REG_ADDR_WIDTH  register-file index for R_in/R_out.
- alu_instruction  out  OPCODE_WIDTH  ALU operation; 0 when not executing.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in the final execute cycle.
- illegal  out  1  one-cycle pulse when an unsupported opcode is detected.
- instr_count  out  COUNT_WIDTH  retired instructions; wraps to 0.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6.
- Opcode classes:
  - ARITH3: 3–11.
  - UNARY: 17 (neg), 18 (not).
  - MULDIV: 15, 16.
  - Every other opcode is illegal.
- Control word per state:
  - T0: PC_out, MAR_in, IncPC, Z_in.
  - T1, first cycle: Zlow_out, PC_in, Read, MDR_in.
  - T1, each of the MEM_WAIT extra cycles: Read and MDR_in only.
  - T2: MDR_out, IR_in.
  - T3, ARITH3: R_out, reg_sel=Rb, Y_in.
  - T3, UNARY: R_out, reg_sel=Rb, alu_instruction=opcode, Z_in.
  - T3, MULDIV: R_out, reg_sel=Ra, Y_in.
  - T4, ARITH3: R_out, reg_sel=Rc, alu_instruction=opcode, Z_in.
  - T4, MULDIV: R_out, reg_sel=Rb, alu_instruction=opcode, Z_in.
  - T5: Zlow_out, plus either R_in with reg_sel=Ra (ARITH3/UNARY) or LO_in (MULDIV).
  - T6, MULDIV only: Zhigh_out, HI_in.
- Transitions:
  - IDLE→T0 when run=1.
  - T0→T1.
  - T1 stays T1 until its wait counter reaches MEM_WAIT, then →T2.
  - T2→T3.
  - T3: UNARY→T5; illegal→IDLE with illegal=1; otherwise →T4.
  - T4→T5.
  - T5: MULDIV→T6; otherwise the instruction ends.
  - T6: the instruction ends.
  - On instruction end: →T0 if run=1, else →IDLE.
- done is asserted in the final execute state; instr_count increments on that edge.
- Illegal instructions do not increment instr_count and do not assert done.
- Outputs are a pure decode of the state register, the T1 wait counter and IR_Data. Unlisted controls are 0.

## Timing
- Reset: on a clk edge with clr=1, state←IDLE, wait counter←0, instr_count←0.
  - All controls, alu_instruction, reg_sel, busy, done and illegal are 0 in the cycle after that edge.
  - clr mid-instruction aborts without write-back.
  - clr has priority over run.
- Latency from leaving IDLE to done, in cycles:
  - ARITH3: 6+MEM_WAIT.
  - UNARY: 5+MEM_WAIT.
  - MULDIV: 7+MEM_WAIT.
- With run held high, the next T0 follows done with no bubble.
- IR_Data is sampled only in T3–T6. It must be stable from the T2 edge until the instruction ends.
- Deasserting run mid-instruction has no effect until the instruction ends.
- instr_count wraps from 2^COUNT_WIDTH−1 to 0.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants (ADD=3 … ROL=11, MUL=15, DIV=16, NEG=17, NOT=18);
  - the state enum;
  - the field-position localparams.
- Sub-module op_class_decode: combinational opcode → {arith3, unary, muldiv, illegal}.
- The FSM, wait counter and instruction counter live in the top module.

## Test plan
- neg R0,R1: IR=0x88080000, run=1 for one cycle, MEM_WAIT=0 → T3 drives R_out, reg_sel=1, alu_instruction=17, Z_in; T5 drives R_in, reg_sel=0; done at cycle 5; instr_count=1; then IDLE.
- add R2,R3,R4: IR=0x191A0000 → reg_sel 3 (T3, Y_in), then 4 (T4, alu_instruction=3), then 2 (T5, R_in); done at cycle 6.
- mul R3,R4: IR=0x79A00000 → LO_in in T5, HI_in in T6; done at cycle 7; R_in never asserted.
- Illegal opcode: IR=0xF8000000 → illegal pulses in T3, then IDLE; done=0; instr_count unchanged.
- MEM_WAIT=2, run held high: Read and MDR_in stay high for 3 consecutive cycles with PC_in only in the first; back-to-back instructions have no idle cycle between done and the next PC_out.
- clr asserted during T4 of an add → all outputs 0 the next cycle; no R_in; instr_count=0; with run=1, a fresh T0 starts one cycle after clr is released.
